// File: rtl/pcode_pkg.sv
// Shared types and constants for the priority-code scanner.
package pcode_pkg;

  localparam int PCODE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/pcode_find.sv
// Combinational priority finder: picks the highest (dir=1) or lowest
// (dir=0) set index of a vector and flags whether any / exactly one bit is set.
module pcode_find #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  input  logic          i_dir,
  output logic [IW-1:0] o_idx,
  output logic          o_found,
  output logic          o_single
);

  // Later loop iterations override earlier ones, so the scan direction
  // decides which end of the vector wins.
  always_comb begin
    o_idx = '0;
    if (i_dir) begin
      for (int i = 0; i < W; i++) begin
        if (i_vec[i]) o_idx = IW'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = IW'(i);
      end
    end
  end

  assign o_found  = |i_vec;
  assign o_single = o_found && ((i_vec & (i_vec - W'(1))) == '0);

endmodule

// File: rtl/pcode_scanner.sv
// Accepts a request vector and emits the index of every set bit, one beat
// per cycle, in MSB-first or LSB-first order, with valid/ready on both sides.
module pcode_scanner
  import pcode_pkg::*;
#(
  parameter int W  = PCODE_W,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in,
  input  logic          dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] code,
  output logic          last,
  output logic          none
);

  state_t        r_state;
  logic [W-1:0]  r_pending;
  logic          r_mode;
  logic          r_out_valid;
  logic [IW-1:0] r_code;
  logic          r_last;
  logic          r_none;

  logic [W-1:0]  w_clr;
  logic [W-1:0]  w_fvec;
  logic          w_fdir;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_single;

  // Pending vector with the currently reported bit removed; this is what
  // the next beat is computed from once the current beat is taken.
  assign w_clr = r_pending & ~(W'(1) << r_code);

  // One finder is shared: in IDLE it looks at the incoming vector so the
  // first beat is ready right after acceptance, in SCAN at the cleared vector.
  assign w_fvec = (r_state == IDLE) ? in  : w_clr;
  assign w_fdir = (r_state == IDLE) ? dir : r_mode;

  pcode_find #(
    .W  (W),
    .IW (IW)
  ) u_find (
    .i_vec    (w_fvec),
    .i_dir    (w_fdir),
    .o_idx    (w_idx),
    .o_found  (w_found),
    .o_single (w_single)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign code      = r_code;
  assign last      = r_last;
  assign none      = r_none;

  // Control FSM with registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_mode      <= 1'b1;
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_last      <= 1'b0;
      r_none      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_pending   <= in;
            r_mode      <= dir;
            r_state     <= SCAN;
            r_out_valid <= 1'b1;
            r_code      <= w_idx;
            // An empty vector still produces one terminating beat.
            r_last      <= w_single || !w_found;
            r_none      <= !w_found;
          end
        end
        SCAN: begin
          if (r_out_valid && out_ready) begin
            r_pending <= w_clr;
            if (r_last) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
            end else begin
              r_code <= w_idx;
              r_last <= w_single;
              r_none <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcode_scanner.sv
// Scoreboard bench for pcode_scanner: a reference model turns each accepted
// vector into its list of expected beats; a monitor checks every DUT beat.
module tb_pcode_scanner;

  localparam int W  = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [IW-1:0] code;
    logic          last;
    logic          none;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in;
  logic          dir;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] code;
  logic          last;
  logic          none;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb[$];
  bit    m_busy = 1'b0;
  int    m_left = 0;
  bit    rdy_rand = 1'b0;

  pcode_scanner #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .last      (last),
    .none      (none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beats for a vector: list of set indices in scan order.
  task automatic expect_vector(input logic [W-1:0] v, input logic d);
    int    idx[$];
    beat_t b;
    for (int i = 0; i < W; i++) if (v[i]) idx.push_back(i);
    if (d) idx.reverse();
    if (idx.size() == 0) begin
      b.code = '0; b.last = 1'b1; b.none = 1'b1;
      sb.push_back(b);
      m_left = 1;
    end else begin
      foreach (idx[k]) begin
        b.code = IW'(idx[k]);
        b.last = (k == idx.size() - 1);
        b.none = 1'b0;
        sb.push_back(b);
      end
      m_left = idx.size();
    end
  endtask

  // Reference model: busy from acceptance until the final beat is taken.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      m_busy = 1'b0;
      m_left = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        expect_vector(in, dir);
        m_busy = 1'b1;
      end
    end else if (out_ready) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
  end

  // Monitor: samples on the falling edge, compares against the model.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_code", code, 0);
      chk("rst_last", last, 0);
      chk("rst_none", none, 0);
    end else begin
      chk("out_valid", out_valid, m_busy);
      chk("in_ready", in_ready, !m_busy);
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got code %0d, expected no beat at %0t", code, $time);
        end else begin
          e = sb[0];
          chk("code", code, e.code);
          chk("last", last, e.last);
          chk("none", none, e.none);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] v, input logic d, input bit hold);
    in       = v;
    dir      = d;
    in_valid = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      if (k == 200) begin
        $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        $fatal(1, "send timeout");
      end
      if (in_ready) begin
        tick();
        break;
      end
      tick();
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k <= 400; k++) begin
      if (k == 400) begin
        $display("FAIL drain_timeout: busy=%0d queued=%0d, expected idle", m_busy, sb.size());
        $fatal(1, "drain timeout");
      end
      if (!m_busy && sb.size() == 0) break;
      tick();
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    dir       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // MSB-first and LSB-first on the same vector, then an empty vector.
    out_ready = 1'b1;
    send(8'b1010_0100, 1'b1, 1'b0);
    drain();
    send(8'b1010_0100, 1'b0, 1'b0);
    drain();
    send(8'h00, 1'b1, 1'b0);
    drain();

    // Full vector with a three-cycle stall on code 6.
    send(8'hFF, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    drain();

    // Reset pulse mid-scan, then a fresh vector on the first edge after.
    send(8'b1000_0011, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    send(8'h01, 1'b0, 1'b0);
    drain();

    // in_valid held with a changing vector while scanning.
    send(8'b1010_0100, 1'b1, 1'b1);
    in = 8'($urandom);
    tick();
    in = 8'($urandom);
    dir = 1'($urandom);
    tick();
    send(8'h18, 1'b0, 1'b0);
    drain();

    // Randomized vectors with random back-pressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send((n % 9 == 0) ? 8'h00 : 8'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
